ethernet_rx: RTL

Ethernet MAC-layer receive parser for the network stack. It accepts the byte stream from the MAC/PHY front end with preamble and SFD already stripped. It checks the destination MAC and decodes the EtherType, then streams the payload to the IP receive stage (`newFrame`/`frameType`/`newFrameByte`/`frameData`) and to ARP. It sits directly below the IP receive block and above the PHY byte interface.

---
 rtl/ethernet_rx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ethernet_rx.sv
// Ethernet receive parser: filters on destination MAC, decodes IPv4/ARP EtherType,
// and streams payload bytes one cycle after each input strobe.
module ethernet_rx #(
  parameter logic [47:0] DEVICE_MAC  = 48'h0050C2_1A2B3C,
  parameter logic [10:0] MAX_PAYLOAD = 11'd1500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxByteValid,
  input  logic [7:0]  rxData,
  input  logic        rxFrameStart,
  input  logic        rxFrameEnd,
  output logic        newFrame,
  output logic        frameType,
  output logic        newFrameByte,
  output logic [7:0]  frameData,
  output logic        frameEnd,
  output logic [10:0] payloadLen,
  output logic [47:0] sourceMAC,
  output logic        frameDropped
);

  typedef enum logic [2:0] {IDLE, DSTMAC, SRCMAC, ETYPE, PAYLOAD, DISCARD} state_t;

  state_t      state;
  logic [3:0]  hdr_cnt;
  logic [39:0] dst_shift;
  logic [47:0] src_stage;
  logic [7:0]  type_hi;
  logic        prev_valid;
  logic        end_pending;
  logic [47:0] dst_next;
  logic [15:0] etype;
  logic        dst_match;

  assign dst_next  = {dst_shift, rxData};
  assign etype     = {type_hi, rxData};
  assign dst_match = (dst_next == DEVICE_MAC) || (dst_next == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      hdr_cnt      <= '0;
      dst_shift    <= '0;
      src_stage    <= '0;
      type_hi      <= '0;
      prev_valid   <= 1'b0;
      end_pending  <= 1'b0;
      newFrame     <= 1'b0;
      frameType    <= 1'b0;
      newFrameByte <= 1'b0;
      frameData    <= '0;
      frameEnd     <= 1'b0;
      payloadLen   <= '0;
      sourceMAC    <= '0;
      frameDropped <= 1'b0;
    end else begin
      newFrame     <= 1'b0;
      newFrameByte <= 1'b0;
      frameDropped <= 1'b0;
      // frameEnd trails the last newFrameByte by one cycle
      frameEnd     <= end_pending;
      end_pending  <= 1'b0;
      prev_valid   <= rxByteValid;

      if (rxByteValid) begin
        if (rxFrameStart) begin
          // A start always restarts parsing; it drops whatever frame was in progress.
          if (state != IDLE || rxFrameEnd) frameDropped <= 1'b1;
          dst_shift <= {32'h0, rxData};
          hdr_cnt   <= 4'd1;
          state     <= rxFrameEnd ? IDLE : DSTMAC;
        end else begin
          case (state)
            IDLE: ;
            DISCARD: if (rxFrameEnd) state <= IDLE;
            default: begin
              if (prev_valid || (state != PAYLOAD && rxFrameEnd)) begin
                // Overrun byte or runt end: reject the frame.
                frameDropped <= 1'b1;
                state        <= rxFrameEnd ? IDLE : DISCARD;
              end else if (state == DSTMAC) begin
                dst_shift <= dst_next[39:0];
                hdr_cnt   <= hdr_cnt + 4'd1;
                if (hdr_cnt == 4'd5) begin
                  if (dst_match) begin
                    state <= SRCMAC;
                  end else begin
                    frameDropped <= 1'b1;
                    state        <= DISCARD;
                  end
                end
              end else if (state == SRCMAC) begin
                src_stage <= {src_stage[39:0], rxData};
                hdr_cnt   <= hdr_cnt + 4'd1;
                if (hdr_cnt == 4'd11) state <= ETYPE;
              end else if (state == ETYPE) begin
                hdr_cnt <= hdr_cnt + 4'd1;
                if (hdr_cnt == 4'd12) begin
                  type_hi <= rxData;
                end else if (etype == 16'h0800 || etype == 16'h0806) begin
                  newFrame   <= 1'b1;
                  frameType  <= (etype == 16'h0800);
                  sourceMAC  <= src_stage;
                  payloadLen <= '0;
                  state      <= PAYLOAD;
                end else begin
                  frameDropped <= 1'b1;
                  state        <= DISCARD;
                end
              end else begin
                if (payloadLen == MAX_PAYLOAD) begin
                  frameDropped <= 1'b1;
                  state        <= rxFrameEnd ? IDLE : DISCARD;
                end else begin
                  frameData    <= rxData;
                  newFrameByte <= 1'b1;
                  payloadLen   <= payloadLen + 11'd1;
                  if (rxFrameEnd) begin
                    end_pending <= 1'b1;
                    state       <= IDLE;
                  end
                end
              end
            end
          endcase
        end
      end
    end
  end

endmodule
